reg_cmd_master: RTL and testbench
=================================

Name: reg_cmd_master

Overview:
- Host-side initiator for the miner register file; the other end of its byte-wide register port.
- Sits between the UART byte receiver/transmitter and the register file.
- Parses host command bytes into register writes (reg_num/reg_write/reg_wdata).
- Performs register reads and streams the read bytes back to the host over a valid/ready TX interface.

Parameters:
- TIMEOUT_CYCLES, 1000000: max idle cycles between bytes inside a command before abort to IDLE.
- MAX_LEN, 76: largest accepted burst length; larger values are clamped to MAX_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received host byte.
- rx_valid  input  1  one-cycle strobe qualifying rx_data; no backpressure.
- tx_data  output  8  byte to host.
- tx_valid  output  1  tx_data valid; held until tx_ready.
- tx_ready  input  1  transmitter accepts tx_data when tx_valid&&tx_ready.
- reg_num  output  7  register address to register file.
- reg_write  output  1  one-cycle write strobe.
- reg_wdata  output  8  write data.
- reg_rdata  input  8  combinational read data for reg_num.
- busy  output  1  high in any state other than IDLE.
- err_count  output  8  saturating count of protocol errors.

Behaviour:
- Reset (async, reset==0): state IDLE; all outputs 0; internal addr/len/timeout counters 0. Reset mid-command drops the command with no further strobes.
- Command format:
  - write = 0x57, addr, len, len data bytes.
  - read = 0x52, addr, len.
  - addr uses bits [6:0]; bit7 ignored.
- States and transitions:
  - IDLE: on rx byte, 0x57->GET_ADDR (op=W); 0x52->GET_ADDR (op=R); any other byte -> err_count+1, stay IDLE.
  - GET_ADDR: rx byte -> addr<=byte[6:0], ->GET_LEN.
  - GET_LEN: rx byte -> len<=min(byte,MAX_LEN).
    - len==0: no-op, ->IDLE; no error.
    - op W: ->WR_DATA.
    - op R: ->RD_ISSUE.
  - WR_DATA: rx byte -> next cycle reg_num=addr, reg_wdata=byte, reg_write=1 for exactly one cycle; addr<=addr+1 (7-bit wrap 127->0); len<=len-1; len reaches 0 -> IDLE (or ACK, see option).
  - RD_ISSUE: drive reg_num=addr for one cycle; ->RD_LATCH.
  - RD_LATCH: tx_data<=reg_rdata, tx_valid<=1; ->RD_SEND.
  - RD_SEND: hold tx_data/tx_valid until tx_ready. On handshake: tx_valid<=0, addr++, len--; len==0 -> IDLE, else RD_ISSUE.
- Read throughput: 3 cycles per byte minimum when tx_ready is constantly high.
- rx byte arriving in RD_ISSUE/RD_LATCH/RD_SEND: dropped, err_count+1.
- Timeout: in GET_ADDR/GET_LEN/WR_DATA, counter resets on each rx byte and increments otherwise; reaching TIMEOUT_CYCLES -> IDLE, err_count+1. Not applied in read states.
- Writes to addr 0..4 are still issued; the register file ignores them.
- err_count saturates at 255; cleared only by reset.
- reg_write never asserts outside WR_DATA; reg_num holds its last value when idle.

Optional Feature:
- Macro CMD_ACK_EN.
- Defined: after the final write byte of a write burst, the block enters ACK and presents tx_data=0x4B with tx_valid=1 until tx_ready, then returns to IDLE; busy stays high during ACK. A len==0 write also sends the ACK.
- Undefined: no ACK state; a write returns to IDLE silently; tx is used only for read data.

Test Plan:
- Write burst: rx 0x57,0x05,0x03,0xAA,0xBB,0xCC -> three reg_write pulses with (reg_num,reg_wdata) = (5,AA),(6,BB),(7,CC); busy low afterwards; err_count=0.
- Read burst: preload regs 5..6 = 0x11,0x22; rx 0x52,0x05,0x02 with tx_ready stalled 4 cycles per byte -> tx emits 0x11 then 0x22; tx_data stable while tx_valid&&!tx_ready.
- Wrap and clamp: rx 0x57,0x7F,0x02,0x01,0x02 -> writes at 127 then 0. rx 0x52,0x00,0xFF -> exactly 76 tx bytes.
- Errors: rx 0x00 in IDLE -> err_count=1. rx 0x57,0x05 then silence for TIMEOUT_CYCLES -> IDLE, err_count=2, no reg_write. rx byte during RD_SEND -> err_count+1, read stream unaffected.
- Reset mid-write: assert reset between the 1st and 2nd data bytes -> all outputs 0 immediately; next command 0x57,0x08,0x01,0x5A writes (8,5A) correctly.
- CMD_ACK_EN defined: write 0x57,0x09,0x01,0x77 -> one reg_write (9,77), then tx 0x4B. Undefined: no tx activity.

Source files
------------

// File: rtl/reg_cmd_master.sv
// rtl/reg_cmd_master.sv - host command parser driving register writes and streaming register reads.
// Optional write acknowledge byte (0x4B) enabled by defining CMD_ACK_EN.
module reg_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_LEN        = 76
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [6:0] reg_num,
  output logic       reg_write,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_LEN, WR_DATA, RD_ISSUE, RD_LATCH, RD_SEND, ACK
  } state_t;

  state_t        state;
  logic          op_wr;
  logic [6:0]    addr;
  logic [7:0]    len;
  logic [TW-1:0] tmo;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      addr      <= '0;
      len       <= '0;
      tmo       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      reg_num   <= '0;
      reg_write <= 1'b0;
      reg_wdata <= '0;
      err_count <= '0;
    end else begin
      reg_write <= 1'b0;
      case (state)
        IDLE: begin
          tmo <= '0;
          if (rx_valid) begin
            if (rx_data == 8'h57) begin
              op_wr <= 1'b1;
              state <= GET_ADDR;
            end else if (rx_data == 8'h52) begin
              op_wr <= 1'b0;
              state <= GET_ADDR;
            end else begin
              err_count <= sat_inc(err_count);
            end
          end
        end
        GET_ADDR, GET_LEN, WR_DATA: begin
          if (rx_valid) begin
            tmo <= '0;
            if (state == GET_ADDR) begin
              addr  <= rx_data[6:0];
              state <= GET_LEN;
            end else if (state == GET_LEN) begin
              len <= (rx_data > MAX_LEN_B) ? MAX_LEN_B : rx_data;
              if (rx_data == 8'd0) begin
`ifdef CMD_ACK_EN
                if (op_wr) begin
                  tx_data  <= 8'h4B;
                  tx_valid <= 1'b1;
                  state    <= ACK;
                end else begin
                  state <= IDLE;
                end
`else
                state <= IDLE;
`endif
              end else begin
                state <= op_wr ? WR_DATA : RD_ISSUE;
              end
            end else begin
              reg_num   <= addr;
              reg_wdata <= rx_data;
              reg_write <= 1'b1;
              addr      <= addr + 7'd1;
              len       <= len - 8'd1;
              if (len == 8'd1) begin
`ifdef CMD_ACK_EN
                tx_data  <= 8'h4B;
                tx_valid <= 1'b1;
                state    <= ACK;
`else
                state <= IDLE;
`endif
              end
            end
          end else if (tmo == TMO_LAST) begin
            tmo       <= '0;
            state     <= IDLE;
            err_count <= sat_inc(err_count);
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RD_ISSUE: begin
          reg_num <= addr;
          state   <= RD_LATCH;
        end
        RD_LATCH: begin
          tx_data  <= reg_rdata;
          tx_valid <= 1'b1;
          state    <= RD_SEND;
        end
        RD_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            addr     <= addr + 7'd1;
            len      <= len - 8'd1;
            state    <= (len == 8'd1) ? IDLE : RD_ISSUE;
          end
        end
`ifdef CMD_ACK_EN
        ACK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
      // Host bytes cannot be accepted while a response is being produced.
      if (rx_valid && (state == RD_ISSUE || state == RD_LATCH || state == RD_SEND || state == ACK))
        err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_reg_cmd_master.sv
// tb/tb_reg_cmd_master.sv - directed bench for reg_cmd_master with a register file model.
module tb_reg_cmd_master;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [6:0] reg_num;
  logic       reg_write;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_count;

  logic [7:0]  regs [128];
  logic [14:0] wr_q [$];
  logic [7:0]  tx_q [$];
  int          total = 0;
  int          bad = 0;
  int          stab_err = 0;
  int          stall = 0;
  int          wait_cnt = 0;
  logic        pend = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  reg_cmd_master #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(76)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_num(reg_num), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
  );

  assign reg_rdata = regs[reg_num];

  always #5 clk = ~clk;

  // Register file, transmitter with optional stall, and handshake recorder.
  always @(negedge clk) begin
    if (pend && (!tx_valid || tx_data !== prev_d)) stab_err++;
    if (!tx_valid) wait_cnt = 0;
    else wait_cnt++;
    tx_ready = (stall == 0) ? 1'b1 : (wait_cnt > 4);
    pend = tx_valid && !tx_ready;
    prev_d = tx_data;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (reg_write) begin
      wr_q.push_back({reg_num, reg_wdata});
      regs[reg_num] = reg_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    cyc(8);
    chk(tag, tx_q.size(), n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_reg_write"}, reg_write, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_reg_num"}, reg_num, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int m;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    cyc(3);
    chk_zero("reset");
    reset = 1'b1;
    cyc(2);

    // Write burst
    send(8'h57); send(8'h05); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    cyc(4);
    chk("wr_n", wr_q.size(), 3);
    chk("wr0", wr_q[0], {7'd5, 8'hAA});
    chk("wr1", wr_q[1], {7'd6, 8'hBB});
    chk("wr2", wr_q[2], {7'd7, 8'hCC});
    chk("wr_busy", busy, 0);
    chk("wr_err", err_count, 0);

    // Read burst with a stalled transmitter
    stall = 1;
    regs[5] = 8'h11;
    regs[6] = 8'h22;
    tx_q.delete();
    send(8'h52); send(8'h05); send(8'h02);
    wait_tx(2, 200, "rd_n");
    chk("rd0", tx_q[0], 8'h11);
    chk("rd1", tx_q[1], 8'h22);
    chk("rd_stable", stab_err, 0);
    chk("rd_busy", busy, 0);

    // Address wrap 127 -> 0
    stall = 0;
    wr_q.delete();
    send(8'h57); send(8'h7F); send(8'h02); send(8'h01); send(8'h02);
    cyc(4);
    chk("wrap_n", wr_q.size(), 2);
    chk("wrap0", wr_q[0], {7'h7F, 8'h01});
    chk("wrap1", wr_q[1], {7'h00, 8'h02});

    // Length clamp to 76
    for (int i = 0; i < 128; i++) regs[i] = 8'(i * 3 + 1);
    tx_q.delete();
    send(8'h52); send(8'h00); send(8'hFF);
    wait_tx(76, 400, "clamp_n");
    m = 0;
    for (int i = 0; i < 76; i++) if (tx_q[i] !== 8'(i * 3 + 1)) m++;
    chk("clamp_data", m, 0);
    chk("clamp_err", err_count, 0);

    // Bad opcode
    send(8'h00);
    cyc(2);
    chk("badop_err", err_count, 1);

    // Timeout inside a command
    wr_q.delete();
    send(8'h57); send(8'h05);
    cyc(TMO - 5);
    chk("tmo_busy_before", busy, 1);
    cyc(10);
    chk("tmo_busy_after", busy, 0);
    chk("tmo_err", err_count, 2);
    chk("tmo_no_write", wr_q.size(), 0);

    // Host byte during RD_SEND
    stall = 1;
    regs[5] = 8'h11;
    regs[6] = 8'h22;
    tx_q.delete();
    send(8'h52); send(8'h05); send(8'h02);
    k = 0;
    while (!tx_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rds_valid_seen", tx_valid, 1);
    send(8'hEE);
    wait_tx(2, 200, "rds_n");
    chk("rds0", tx_q[0], 8'h11);
    chk("rds1", tx_q[1], 8'h22);
    chk("rds_err", err_count, 3);
    chk("rds_stable", stab_err, 0);

    // Reset in the middle of a write burst
    stall = 0;
    send(8'h57); send(8'h05); send(8'h03); send(8'hAA);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    cyc(1);
    reset = 1'b1;
    cyc(2);
    wr_q.delete();
    tx_q.delete();
    send(8'h57); send(8'h08); send(8'h01); send(8'h5A);
    cyc(4);
    chk("post_rst_n", wr_q.size(), 1);
    chk("post_rst_wr", wr_q[0], {7'd8, 8'h5A});
    chk("post_rst_err", err_count, 0);

    // Write acknowledge behaviour
    tx_q.delete();
    wr_q.delete();
    send(8'h57); send(8'h09); send(8'h01); send(8'h77);
    cyc(6);
    chk("ack_wr_n", wr_q.size(), 1);
    chk("ack_wr", wr_q[0], {7'd9, 8'h77});
`ifdef CMD_ACK_EN
    chk("ack_tx_n", tx_q.size(), 1);
    chk("ack_tx", tx_q[0], 8'h4B);
`else
    chk("ack_tx_n", tx_q.size(), 0);
`endif
    chk("ack_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
